// File: rtl/wb_uart_pkg.sv
// rtl/wb_uart_pkg.sv - shared constants and FSM encoding for the wb_uart stream bridge
package wb_uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [31:0] RX_ADDR_DEF = 32'h0000_0011;
    localparam logic [31:0] TX_ADDR_DEF = 32'h0000_0012;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_STB  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_STB  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/wb_uart_stream_bridge_if.sv
// rtl/wb_uart_stream_bridge_if.sv - Wishbone master port plus RX/TX byte streams of the bridge
interface wb_uart_stream_bridge_if;
    import wb_uart_pkg::*;

    logic [31:0]       o_wb_addr;
    logic [31:0]       o_wb_data;
    logic [31:0]       i_wb_data;
    logic              o_wb_we;
    logic              o_wb_stb;
    logic              i_rx_byte_available;
    logic              i_tx_fifo_full;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              i_rx_ready;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;

    // Bridge side
    modport master (
        output o_wb_addr, o_wb_data, o_wb_we, o_wb_stb,
        input  i_wb_data, i_rx_byte_available, i_tx_fifo_full,
        output o_rx_data, o_rx_valid,
        input  i_rx_ready, i_tx_data, i_tx_valid,
        output o_tx_ready
    );

    // wb_uart and stream-user side
    modport slave (
        input  o_wb_addr, o_wb_data, o_wb_we, o_wb_stb,
        output i_wb_data, i_rx_byte_available, i_tx_fifo_full,
        input  o_rx_data, o_rx_valid,
        output i_rx_ready, i_tx_data, i_tx_valid,
        input  o_tx_ready
    );

endinterface

// File: rtl/wb_uart_stream_bridge_byte_fifo2.sv
// rtl/wb_uart_stream_bridge_byte_fifo2.sv - 2-entry byte skid buffer with push/pop/count
module byte_fifo2
    import wb_uart_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count
);

    logic [1:0][DATA_W-1:0] mem_q, mem_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   do_push, do_pop;

    // Pointer/count update; a push into a full buffer only lands if a pop frees a slot
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_pop   = i_pop && (count_q != 2'd0);
        do_push  = i_push && ((count_q != 2'd2) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    // Storage and pointer registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/wb_uart_stream_bridge.sv
// rtl/wb_uart_stream_bridge.sv - Wishbone master moving bytes between wb_uart FIFOs and valid/ready streams
module wb_uart_stream_bridge
    import wb_uart_pkg::*;
#(
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] RX_ADDR    = RX_ADDR_DEF,
    parameter logic [31:0] TX_ADDR    = TX_ADDR_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    wb_uart_stream_bridge_if.master bus
);

    bridge_state_e     state_q, state_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              last_grant_q, last_grant_d;   // 1 = last grant was a write
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic [31:0]       wb_addr_q, wb_addr_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_we_q, wb_we_d;

    logic              rd_req, wr_req, grant_rd, grant_wr, tx_accept;
    logic              rx_push, rx_pop, rx_valid;
    logic [1:0]        rx_count;
    logic [DATA_W-1:0] rx_head;

    assign rx_valid = (rx_count != 2'd0);
    assign rx_pop   = rx_valid && bus.i_rx_ready;

    byte_fifo2 u_rx_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (rx_push),
        .i_push_data (bus.i_wb_data[DATA_W-1:0]),
        .i_pop       (rx_pop),
        .o_head      (rx_head),
        .o_count     (rx_count)
    );

    // Arbitration, bus sequencing and TX holding register next-state
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        last_grant_d = last_grant_q;
        tx_full_d    = tx_full_q;
        tx_byte_d    = tx_byte_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_we_d      = wb_we_q;
        rx_push      = 1'b0;
        grant_rd     = 1'b0;
        grant_wr     = 1'b0;
        // Only IDLE issues reads, and nothing is in flight there, so a free slot suffices
        rd_req       = bus.i_rx_byte_available && (rx_count < 2'd2);
        wr_req       = tx_full_q && !bus.i_tx_fifo_full;
        tx_accept    = bus.i_tx_valid && !tx_full_q;

        if (tx_accept) begin
            tx_full_d = 1'b1;
            tx_byte_d = bus.i_tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                grant_rd = rd_req && (!wr_req || last_grant_q);
                grant_wr = wr_req && !grant_rd;
                if (grant_rd) begin
                    state_d      = ST_RD_STB;
                    wb_addr_d    = RX_ADDR;
                    wb_we_d      = 1'b0;
                    last_grant_d = 1'b0;
                end else if (grant_wr) begin
                    state_d      = ST_WR_STB;
                    wb_addr_d    = TX_ADDR;
                    wb_we_d      = 1'b1;
                    wb_data_d    = {24'h0, tx_byte_q};
                    last_grant_d = 1'b1;
                end
            end
            ST_RD_STB: begin
                wait_cnt_d = 3'(RD_LATENCY);
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 3'd1) begin
                    rx_push = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_WR_STB: begin
                tx_full_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and holding registers; reset aborts any transaction in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 3'd0;
            last_grant_q <= 1'b0;
            tx_full_q    <= 1'b0;
            tx_byte_q    <= '0;
            wb_addr_q    <= 32'h0;
            wb_data_q    <= 32'h0;
            wb_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            last_grant_q <= last_grant_d;
            tx_full_q    <= tx_full_d;
            tx_byte_q    <= tx_byte_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_we_q      <= wb_we_d;
        end
    end

    assign bus.o_wb_stb   = (state_q == ST_RD_STB) || (state_q == ST_WR_STB);
    assign bus.o_wb_addr  = wb_addr_q;
    assign bus.o_wb_data  = wb_data_q;
    assign bus.o_wb_we    = wb_we_q;
    assign bus.o_rx_valid = rx_valid;
    assign bus.o_rx_data  = rx_head;
    assign bus.o_tx_ready = !tx_full_q;

endmodule

// File: tb/tb_wb_uart_stream_bridge.sv
// tb/tb_wb_uart_stream_bridge.sv - directed self-checking bench for wb_uart_stream_bridge
module tb_wb_uart_stream_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    wb_uart_stream_bridge_if bus_a ();
    wb_uart_stream_bridge_if bus_b ();

    wb_uart_stream_bridge #(.RD_LATENCY(1)) dut_a (
        .i_clk   (clk),
        .i_reset (rst_a),
        .bus     (bus_a)
    );

    wb_uart_stream_bridge #(.RD_LATENCY(2)) dut_b (
        .i_clk   (clk),
        .i_reset (rst_b),
        .bus     (bus_b)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          rd_cnt_a = 0;
    int          wr_cnt_a = 0;
    int          rd_cnt_b = 0;
    logic [3:0]  rd_sh_a  = 4'h0;
    logic [3:0]  rd_sh_b  = 4'h0;
    logic [7:0]  we_seq_a = 8'h0;
    logic [31:0] last_wr_data_a = 32'h0;

    // wb_uart model: count strobes, remember write data, age read strobes
    always @(posedge clk) begin
        rd_sh_a <= {rd_sh_a[2:0], bus_a.o_wb_stb & ~bus_a.o_wb_we};
        rd_sh_b <= {rd_sh_b[2:0], bus_b.o_wb_stb & ~bus_b.o_wb_we};
        if (bus_a.o_wb_stb) begin
            we_seq_a <= {we_seq_a[6:0], bus_a.o_wb_we};
            if (bus_a.o_wb_we) begin
                wr_cnt_a       <= wr_cnt_a + 1;
                last_wr_data_a <= bus_a.o_wb_data;
            end else begin
                rd_cnt_a <= rd_cnt_a + 1;
            end
        end
        if (bus_b.o_wb_stb && !bus_b.o_wb_we) rd_cnt_b <= rd_cnt_b + 1;
    end

    // Read data is valid only in the cycle exactly RD_LATENCY after the strobe; n-th read returns base+n-1
    assign bus_a.i_wb_data = rd_sh_a[0] ? {24'h0, 8'(32'h41 + rd_cnt_a - 1)} : 32'h0000_00EE;
    assign bus_b.i_wb_data = rd_sh_b[1] ? {24'h0, 8'(32'h60 + rd_cnt_b - 1)} : 32'h0000_00EE;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus_a.i_rx_byte_available = 1'b0;
        bus_a.i_tx_fifo_full      = 1'b0;
        bus_a.i_rx_ready          = 1'b0;
        bus_a.i_tx_data           = 8'h00;
        bus_a.i_tx_valid          = 1'b0;
        bus_b.i_rx_byte_available = 1'b0;
        bus_b.i_tx_fifo_full      = 1'b0;
        bus_b.i_rx_ready          = 1'b0;
        bus_b.i_tx_data           = 8'h00;
        bus_b.i_tx_valid          = 1'b0;

        // Reset values
        step(3);
        chk("rst_stb",      bus_a.o_wb_stb,   0);
        chk("rst_addr",     bus_a.o_wb_addr,  32'h0);
        chk("rst_we",       bus_a.o_wb_we,    0);
        chk("rst_data",     bus_a.o_wb_data,  32'h0);
        chk("rst_rx_valid", bus_a.o_rx_valid, 0);
        chk("rst_rx_data",  bus_a.o_rx_data,  8'h00);
        chk("rst_tx_ready", bus_a.o_tx_ready, 1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Two reads drained straight through with ready high
        bus_a.i_rx_byte_available = 1'b1;
        bus_a.i_rx_ready          = 1'b1;
        step(1);
        chk("rd1_stb",  bus_a.o_wb_stb,  1);
        chk("rd1_addr", bus_a.o_wb_addr, 32'h11);
        chk("rd1_we",   bus_a.o_wb_we,   0);
        step(1);
        chk("rd1_wait_stb",   bus_a.o_wb_stb,   0);
        chk("rd1_wait_valid", bus_a.o_rx_valid, 0);
        step(1);
        chk("rd1_valid", bus_a.o_rx_valid, 1);
        chk("rd1_byte",  bus_a.o_rx_data,  8'h41);
        step(1);
        chk("rd2_stb",       bus_a.o_wb_stb,   1);
        chk("rd1_one_cycle", bus_a.o_rx_valid, 0);
        bus_a.i_rx_byte_available = 1'b0;
        step(1);
        chk("rd2_wait_valid", bus_a.o_rx_valid, 0);
        step(1);
        chk("rd2_valid", bus_a.o_rx_valid, 1);
        chk("rd2_byte",  bus_a.o_rx_data,  8'h42);
        step(1);
        chk("rd2_one_cycle", bus_a.o_rx_valid, 0);
        chk("rd_count_2",    rd_cnt_a,         2);

        // Back-pressure: buffer fills with two bytes, then one pop allows one more read
        bus_a.i_rx_ready          = 1'b0;
        bus_a.i_rx_byte_available = 1'b1;
        step(12);
        chk("bp_reads",    rd_cnt_a,         4);
        chk("bp_valid",    bus_a.o_rx_valid, 1);
        chk("bp_head",     bus_a.o_rx_data,  8'h43);
        chk("bp_stb_idle", bus_a.o_wb_stb,   0);
        bus_a.i_rx_ready = 1'b1;
        step(1);
        bus_a.i_rx_ready = 1'b0;
        chk("bp_pop_head", bus_a.o_rx_data, 8'h44);
        step(10);
        chk("bp_one_more", rd_cnt_a,        5);
        chk("bp_head2",    bus_a.o_rx_data, 8'h44);
        bus_a.i_rx_byte_available = 1'b0;
        bus_a.i_rx_ready          = 1'b1;
        step(3);
        chk("bp_drained", bus_a.o_rx_valid, 0);

        // Single TX byte
        bus_a.i_tx_data  = 8'h5A;
        bus_a.i_tx_valid = 1'b1;
        chk("tx_ready_pre", bus_a.o_tx_ready, 1);
        step(1);
        bus_a.i_tx_valid = 1'b0;
        chk("tx_ready_held", bus_a.o_tx_ready, 0);
        chk("tx_no_stb_yet", bus_a.o_wb_stb,   0);
        step(1);
        chk("tx_stb",      bus_a.o_wb_stb,   1);
        chk("tx_we",       bus_a.o_wb_we,    1);
        chk("tx_addr",     bus_a.o_wb_addr,  32'h12);
        chk("tx_data",     bus_a.o_wb_data,  32'h0000_005A);
        chk("tx_ready_in", bus_a.o_tx_ready, 0);
        step(1);
        chk("tx_stb_done",  bus_a.o_wb_stb,   0);
        chk("tx_ready_ret", bus_a.o_tx_ready, 1);
        chk("tx_wr_count",  wr_cnt_a,         1);

        // TX FIFO full blocks the write until it clears
        bus_a.i_tx_fifo_full = 1'b1;
        bus_a.i_tx_data      = 8'h77;
        bus_a.i_tx_valid     = 1'b1;
        step(1);
        bus_a.i_tx_valid = 1'b0;
        step(5);
        chk("full_no_write", wr_cnt_a,         1);
        chk("full_held",     bus_a.o_tx_ready, 0);
        chk("full_no_stb",   bus_a.o_wb_stb,   0);
        bus_a.i_tx_fifo_full = 1'b0;
        step(2);
        chk("full_released", wr_cnt_a,       2);
        chk("full_wr_data",  last_wr_data_a, 32'h0000_0077);

        // Both paths busy: strobes must alternate
        bus_a.i_tx_data           = 8'h33;
        bus_a.i_tx_valid          = 1'b1;
        bus_a.i_rx_byte_available = 1'b1;
        bus_a.i_rx_ready          = 1'b1;
        step(30);
        chk("alternate", {31'h0, (we_seq_a == 8'b0101_0101) || (we_seq_a == 8'b1010_1010)}, 1);
        bus_a.i_tx_valid          = 1'b0;
        bus_a.i_rx_byte_available = 1'b0;
        step(10);
        chk("alt_tx_ready", bus_a.o_tx_ready, 1);
        chk("alt_rx_empty", bus_a.o_rx_valid, 0);

        // RD_LATENCY=2: reset in the cycle after a read strobe discards the read
        bus_b.i_rx_byte_available = 1'b1;
        bus_b.i_rx_ready          = 1'b1;
        step(1);
        chk("b_rd_stb",  bus_b.o_wb_stb,  1);
        chk("b_rd_addr", bus_b.o_wb_addr, 32'h11);
        step(1);
        rst_b                     = 1'b1;
        bus_b.i_rx_byte_available = 1'b0;
        step(1);
        chk("b_rst_stb",      bus_b.o_wb_stb,   0);
        chk("b_rst_addr",     bus_b.o_wb_addr,  32'h0);
        chk("b_rst_we",       bus_b.o_wb_we,    0);
        chk("b_rst_valid",    bus_b.o_rx_valid, 0);
        chk("b_rst_data",     bus_b.o_rx_data,  8'h00);
        chk("b_rst_tx_ready", bus_b.o_tx_ready, 1);
        rst_b = 1'b0;
        step(5);
        chk("b_discarded", bus_b.o_rx_valid, 0);
        chk("b_rd_once",   rd_cnt_b,         1);
        bus_b.i_rx_byte_available = 1'b1;
        bus_b.i_rx_ready          = 1'b0;
        step(14);
        chk("b_reads",  rd_cnt_b,         3);
        chk("b_valid",  bus_b.o_rx_valid, 1);
        chk("b_head",   bus_b.o_rx_data,  8'h61);
        bus_b.i_rx_ready = 1'b1;
        bus_b.i_rx_byte_available = 1'b0;
        step(1);
        chk("b_head2",  bus_b.o_rx_data,  8'h62);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
